// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences PC redirects for traps, mret and taken branches.
// A trap additionally writes mepc, mcause and mtval, one CSR per cycle.
// Every sequence ends with a FLUSH_CYCLES-long flush before returning to idle.
module trap_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trap_taken,
  input  logic [4:0]  trap_src,
  input  logic        branch_taken,
  input  logic        mret,
  input  logic [31:0] jump_target,
  input  logic [31:0] pc,
  input  logic [31:0] mtval_in,
  input  logic [31:0] mepc_rdata,
  output logic        pipe_flush,
  output logic        busy,
  output logic        pc_load,
  output logic [31:0] pc_next,
  output logic        csr_we,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CAUSE_W = 5;
  localparam int unsigned CSR_AW  = 12;
  localparam int unsigned CNT_W   = 4;

  localparam logic [CSR_AW-1:0] CSR_MEPC   = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE = 12'h342;
  localparam logic [CSR_AW-1:0] CSR_MTVAL  = 12'h343;

  // Counter value loaded on FLUSH entry; the exit happens when it reaches zero.
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REDIRECT,
    S_W_MEPC,
    S_W_MCAUSE,
    S_W_MTVAL,
    S_FLUSH
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_trap;
  logic [XLEN-1:0]     r_epc;
  logic [CAUSE_W-1:0]  r_cause;
  logic [XLEN-1:0]     r_tval;
  logic                r_active;
  logic                r_pc_load;
  logic [XLEN-1:0]     r_pc_next;
  logic                r_csr_we;
  logic [CSR_AW-1:0]   r_csr_addr;
  logic [XLEN-1:0]     r_csr_wdata;

  logic                w_event;

  // Any redirect request seen this cycle (only acted on in idle).
  assign w_event = trap_taken | mret | branch_taken;

  // State sequencing with outputs registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_trap      <= 1'b0;
      r_epc       <= '0;
      r_cause     <= '0;
      r_tval      <= '0;
      r_active    <= 1'b0;
      r_pc_load   <= 1'b0;
      r_pc_next   <= '0;
      r_csr_we    <= 1'b0;
      r_csr_addr  <= '0;
      r_csr_wdata <= '0;
    end else begin
      // Strobes and CSR bus return to zero unless the next state drives them.
      r_pc_load   <= 1'b0;
      r_csr_we    <= 1'b0;
      r_csr_addr  <= '0;
      r_csr_wdata <= '0;

      case (r_state)
        S_IDLE: begin
          if (w_event) begin
            r_state   <= S_REDIRECT;
            r_active  <= 1'b1;
            r_pc_load <= 1'b1;
            if (trap_taken) begin
              r_trap    <= 1'b1;
              r_pc_next <= jump_target;
              r_epc     <= pc;
              r_cause   <= trap_src;
              r_tval    <= mtval_in;
            end else if (mret) begin
              r_trap    <= 1'b0;
              r_pc_next <= mepc_rdata;
            end else begin
              r_trap    <= 1'b0;
              r_pc_next <= jump_target;
            end
          end
        end

        S_REDIRECT: begin
          if (r_trap) begin
            r_state     <= S_W_MEPC;
            r_csr_we    <= 1'b1;
            r_csr_addr  <= CSR_MEPC;
            r_csr_wdata <= r_epc;
          end else begin
            r_state <= S_FLUSH;
            r_cnt   <= FLUSH_LOAD;
          end
        end

        S_W_MEPC: begin
          r_state     <= S_W_MCAUSE;
          r_csr_we    <= 1'b1;
          r_csr_addr  <= CSR_MCAUSE;
          r_csr_wdata <= XLEN'(r_cause);
        end

        S_W_MCAUSE: begin
          r_state     <= S_W_MTVAL;
          r_csr_we    <= 1'b1;
          r_csr_addr  <= CSR_MTVAL;
          r_csr_wdata <= r_tval;
        end

        S_W_MTVAL: begin
          r_state <= S_FLUSH;
          r_cnt   <= FLUSH_LOAD;
        end

        S_FLUSH: begin
          if (r_cnt == '0) begin
            r_state  <= S_IDLE;
            r_active <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign pipe_flush = r_active;
  assign busy       = r_active;
  assign pc_load    = r_pc_load;
  assign pc_next    = r_pc_next;
  assign csr_we     = r_csr_we;
  assign csr_addr   = r_csr_addr;
  assign csr_wdata  = r_csr_wdata;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: three instances with FLUSH_CYCLES = 1, 2, 15
// share the stimulus; each test checks the instance it targets.
module tb_trap_ctrl;

  logic        clk;
  logic        rst_n;
  logic        trap_taken;
  logic [4:0]  trap_src;
  logic        branch_taken;
  logic        mret;
  logic [31:0] jump_target;
  logic [31:0] pc;
  logic [31:0] mtval_in;
  logic [31:0] mepc_rdata;

  logic        pf [3];
  logic        bz [3];
  logic        pl [3];
  logic [31:0] pn [3];
  logic        we [3];
  logic [11:0] ca [3];
  logic [31:0] cd [3];

  int errors = 0;
  int checks = 0;
  int n_load = 0;

  trap_ctrl #(.FLUSH_CYCLES(1)) u_f1 (
    .clk(clk), .rst_n(rst_n), .trap_taken(trap_taken), .trap_src(trap_src),
    .branch_taken(branch_taken), .mret(mret), .jump_target(jump_target), .pc(pc),
    .mtval_in(mtval_in), .mepc_rdata(mepc_rdata), .pipe_flush(pf[0]), .busy(bz[0]),
    .pc_load(pl[0]), .pc_next(pn[0]), .csr_we(we[0]), .csr_addr(ca[0]), .csr_wdata(cd[0]));

  trap_ctrl #(.FLUSH_CYCLES(2)) u_f2 (
    .clk(clk), .rst_n(rst_n), .trap_taken(trap_taken), .trap_src(trap_src),
    .branch_taken(branch_taken), .mret(mret), .jump_target(jump_target), .pc(pc),
    .mtval_in(mtval_in), .mepc_rdata(mepc_rdata), .pipe_flush(pf[1]), .busy(bz[1]),
    .pc_load(pl[1]), .pc_next(pn[1]), .csr_we(we[1]), .csr_addr(ca[1]), .csr_wdata(cd[1]));

  trap_ctrl #(.FLUSH_CYCLES(15)) u_f15 (
    .clk(clk), .rst_n(rst_n), .trap_taken(trap_taken), .trap_src(trap_src),
    .branch_taken(branch_taken), .mret(mret), .jump_target(jump_target), .pc(pc),
    .mtval_in(mtval_in), .mepc_rdata(mepc_rdata), .pipe_flush(pf[2]), .busy(bz[2]),
    .pc_load(pl[2]), .pc_next(pn[2]), .csr_we(we[2]), .csr_addr(ca[2]), .csr_wdata(cd[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: count and report.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    trap_taken   = 1'b0;
    trap_src     = 5'h1f;
    branch_taken = 1'b0;
    mret         = 1'b0;
    jump_target  = '0;
    pc           = '0;
    mtval_in     = '0;
    mepc_rdata   = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Per-cycle expectation for the FLUSH_CYCLES=2 instance.
  task automatic exp_cyc(input string tag, input logic f, input logic l, input logic w,
                         input logic [11:0] a, input logic [31:0] d, input logic [31:0] n);
    check({tag, ".flush"}, 32'(pf[1]), 32'(f));
    check({tag, ".busy"},  32'(bz[1]), 32'(f));
    check({tag, ".load"},  32'(pl[1]), 32'(l));
    check({tag, ".we"},    32'(we[1]), 32'(w));
    check({tag, ".addr"},  32'(ca[1]), 32'(a));
    check({tag, ".wdata"}, cd[1], d);
    check({tag, ".pcnext"}, pn[1], n);
    n_load += int'(pl[1]);
  endtask

  // Count flush cycles of one instance, stopping at its first idle cycle.
  task automatic flush_len(input int idx, output int len);
    len = 0;
    while (pf[idx] && len < 40) begin
      len++;
      tick();
    end
  endtask

  // Back-to-back branches on one instance; both flush windows must be 1+F long.
  task automatic b2b(input int idx, input int fc, input string tag);
    int len;
    do_reset();
    branch_taken = 1'b1;
    jump_target  = 32'h0000_1000;
    tick();
    branch_taken = 1'b0;
    check({tag, ".first.load"}, 32'(pl[idx]), 32'd1);
    flush_len(idx, len);
    check({tag, ".first.len"}, 32'(len), 32'(fc + 1));
    branch_taken = 1'b1;
    jump_target  = 32'h0000_2000;
    tick();
    branch_taken = 1'b0;
    check({tag, ".second.load"}, 32'(pl[idx]), 32'd1);
    check({tag, ".second.pcnext"}, pn[idx], 32'h0000_2000);
    flush_len(idx, len);
    check({tag, ".second.len"}, 32'(len), 32'(fc + 1));
  endtask

  initial begin
    rst_n = 1'b0;
    do_reset();

    // Reset state of all instances.
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst%0d.flush", i), 32'(pf[i]), 32'd0);
      check($sformatf("rst%0d.load", i), 32'(pl[i]), 32'd0);
      check($sformatf("rst%0d.pcnext", i), pn[i], 32'd0);
      check($sformatf("rst%0d.we", i), 32'(we[i]), 32'd0);
      check($sformatf("rst%0d.wdata", i), cd[i], 32'd0);
    end

    // Trap, mret and branch together: trap wins; branch during W_MCAUSE ignored.
    trap_taken   = 1'b1;
    mret         = 1'b1;
    branch_taken = 1'b1;
    pc           = 32'h0000_0100;
    jump_target  = 32'h8000_0008;
    trap_src     = 5'd2;
    mtval_in     = 32'hDEAD_BEEF;
    mepc_rdata   = 32'h0000_0104;
    tick();
    clear_inputs();
    n_load = 0;
    exp_cyc("trap.c1", 1, 1, 0, 12'h000, 32'h0, 32'h8000_0008);
    tick();
    exp_cyc("trap.c2", 1, 0, 1, 12'h341, 32'h0000_0100, 32'h8000_0008);
    tick();
    exp_cyc("trap.c3", 1, 0, 1, 12'h342, 32'h0000_0002, 32'h8000_0008);
    branch_taken = 1'b1;
    jump_target  = 32'h0000_0555;
    tick();
    clear_inputs();
    exp_cyc("trap.c4", 1, 0, 1, 12'h343, 32'hDEAD_BEEF, 32'h8000_0008);
    tick();
    exp_cyc("trap.c5", 1, 0, 0, 12'h000, 32'h0, 32'h8000_0008);
    tick();
    exp_cyc("trap.c6", 1, 0, 0, 12'h000, 32'h0, 32'h8000_0008);
    tick();
    exp_cyc("trap.c7", 0, 0, 0, 12'h000, 32'h0, 32'h8000_0008);
    check("trap.loads", 32'(n_load), 32'd1);

    // Trap with the "none" cause code is still sequenced and writes 31.
    trap_taken  = 1'b1;
    trap_src    = 5'h1f;
    jump_target = 32'h0000_0040;
    pc          = 32'h0000_0300;
    mtval_in    = 32'h0000_0011;
    tick();
    clear_inputs();
    tick();
    exp_cyc("src31.c2", 1, 0, 1, 12'h341, 32'h0000_0300, 32'h0000_0040);
    tick();
    exp_cyc("src31.c3", 1, 0, 1, 12'h342, 32'h0000_001f, 32'h0000_0040);
    for (int i = 0; i < 4; i++) tick();
    exp_cyc("src31.idle", 0, 0, 0, 12'h000, 32'h0, 32'h0000_0040);

    // Taken branch: redirect then two flush cycles, no CSR writes.
    branch_taken = 1'b1;
    jump_target  = 32'h0000_0200;
    tick();
    clear_inputs();
    exp_cyc("br.c1", 1, 1, 0, 12'h000, 32'h0, 32'h0000_0200);
    tick();
    exp_cyc("br.c2", 1, 0, 0, 12'h000, 32'h0, 32'h0000_0200);
    tick();
    exp_cyc("br.c3", 1, 0, 0, 12'h000, 32'h0, 32'h0000_0200);
    tick();
    exp_cyc("br.c4", 0, 0, 0, 12'h000, 32'h0, 32'h0000_0200);

    // mret redirects to mepc, not jump_target.
    mret        = 1'b1;
    mepc_rdata  = 32'h0000_0104;
    jump_target = 32'h0000_0999;
    tick();
    clear_inputs();
    exp_cyc("mret.c1", 1, 1, 0, 12'h000, 32'h0, 32'h0000_0104);
    tick();
    exp_cyc("mret.c2", 1, 0, 0, 12'h000, 32'h0, 32'h0000_0104);
    tick();
    exp_cyc("mret.c3", 1, 0, 0, 12'h000, 32'h0, 32'h0000_0104);
    tick();
    exp_cyc("mret.c4", 0, 0, 0, 12'h000, 32'h0, 32'h0000_0104);

    // Reset during W_MCAUSE aborts: no mtval write, everything zero.
    trap_taken  = 1'b1;
    trap_src    = 5'd7;
    jump_target = 32'h0000_0080;
    pc          = 32'h0000_0400;
    mtval_in    = 32'h1234_5678;
    tick();
    clear_inputs();
    tick();
    tick();
    exp_cyc("abort.mcause", 1, 0, 1, 12'h342, 32'h0000_0007, 32'h0000_0080);
    rst_n = 1'b0;
    tick();
    exp_cyc("abort.rst", 0, 0, 0, 12'h000, 32'h0, 32'h0);
    rst_n = 1'b1;
    tick();
    exp_cyc("abort.rel1", 0, 0, 0, 12'h000, 32'h0, 32'h0);
    tick();
    exp_cyc("abort.rel2", 0, 0, 0, 12'h000, 32'h0, 32'h0);
    branch_taken = 1'b1;
    jump_target  = 32'h0000_0300;
    tick();
    clear_inputs();
    exp_cyc("abort.br", 1, 1, 0, 12'h000, 32'h0, 32'h0000_0300);

    // Flush length at the parameter extremes, back-to-back branches.
    b2b(0, 1, "b2b_f1");
    b2b(2, 15, "b2b_f15");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 The block SHALL have parameter FLUSH_CYCLES, default 2, legal 1..15, giving the number of post-redirect flush cycles.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port trap_taken  input  1  trap request from the jump unit.
REQ-005 The block SHALL have port trap_src  input  5  trap cause code (5'b11111 = none).
REQ-006 The block SHALL have port branch_taken  input  1  branch/jump resolved taken.
REQ-007 The block SHALL have port mret  input  1  mret instruction in execute.
REQ-008 The block SHALL have port jump_target  input  32  redirect address for trap, branch or jump.
REQ-009 The block SHALL have port pc  input  32  PC of the instruction in execute.
REQ-010 The block SHALL have port mtval_in  input  32  faulting address or instruction word.
REQ-011 The block SHALL have port mepc_rdata  input  32  current mepc CSR value.
REQ-012 The block SHALL have port pipe_flush  output  1  squash the younger pipeline stages.
REQ-013 The block SHALL have port busy  output  1  controller not idle, so stall fetch.
REQ-014 The block SHALL have port pc_load  output  1  one-cycle PC load strobe.
REQ-015 The block SHALL have port pc_next  output  32  PC load value.
REQ-016 The block SHALL have port csr_we  output  1  CSR write strobe.
REQ-017 The block SHALL have port csr_addr  output  12  CSR write address.
REQ-018 The block SHALL have port csr_wdata  output  32  CSR write data.

Function
REQ-019 The FSM SHALL have states IDLE, REDIRECT, W_MEPC, W_MCAUSE, W_MTVAL and FLUSH; all outputs SHALL be decoded from registered state only (Moore).
REQ-020 Events SHALL be sampled only in IDLE, with priority trap_taken > mret > branch_taken; events in any other state SHALL be ignored, with no queuing.
REQ-021 On a sampled trap, the block SHALL latch jump_target as target, pc as epc, trap_src as cause and mtval_in as tval; next state REDIRECT with trap flag set.
REQ-022 On a sampled mret, the block SHALL latch mepc_rdata as target; next state REDIRECT with trap flag clear.
REQ-023 On a sampled branch_taken, the block SHALL latch jump_target as target; next state REDIRECT with trap flag clear.
REQ-024 REDIRECT SHALL last one cycle with pc_load=1 and pc_next=target; next state W_MEPC if trap flag, else FLUSH.
REQ-025 W_MEPC SHALL drive csr_we=1, csr_addr=12'h341, csr_wdata=epc.
REQ-026 W_MCAUSE SHALL drive csr_we=1, csr_addr=12'h342, csr_wdata={27'b0, cause}.
REQ-027 W_MTVAL SHALL drive csr_we=1, csr_addr=12'h343, csr_wdata=tval; next state FLUSH.
REQ-028 Each W_* state SHALL last exactly one cycle, in the order shown.
REQ-029 On FLUSH entry, a 4-bit counter SHALL load FLUSH_CYCLES-1 and decrement each cycle; FLUSH SHALL exit to IDLE in the cycle the counter is 0, giving exactly FLUSH_CYCLES cycles.
REQ-030 pipe_flush and busy SHALL be 1 in every state except IDLE, and 0 in IDLE.
REQ-031 Outside REDIRECT, pc_load SHALL be 0 and pc_next SHALL hold its last value.
REQ-032 Outside W_* states, csr_we SHALL be 0 and csr_addr and csr_wdata SHALL be 0.
REQ-033 Trap sequence latency SHALL be 4+FLUSH_CYCLES cycles from the sample edge to IDLE.
REQ-034 Branch and mret sequence latency SHALL be 1+FLUSH_CYCLES cycles from the sample edge to IDLE.
REQ-035 A new event SHALL be accepted on the first IDLE cycle after a sequence completes, with no dead cycle.
REQ-036 A trap with trap_src=5'b11111 SHALL still be sequenced, writing cause 31.

Reset
REQ-037 When rst_n=0 at a clock edge, state SHALL become IDLE, the counter 0, all latches 0 and all outputs 0, including pc_next.
REQ-038 Reset asserted mid-sequence SHALL abort the sequence with no further CSR write, and no partial write SHALL follow reset release.
REQ-039 No output SHALL change on the rst_n edge except at a clk edge.

Verification
REQ-040 Trap with pc=0x100, jump_target=0x8000_0008, trap_src=2, mtval_in=0xDEAD_BEEF, FLUSH_CYCLES=2 -> pc_load with 0x8000_0008 at cycle 1; writes 341=0x100, 342=0x2, 343=0xDEADBEEF at cycles 2-4; pipe_flush 1 for cycles 1-6; IDLE at cycle 7.
REQ-041 branch_taken with jump_target=0x200 -> pc_load with 0x200 at cycle 1; no csr_we; pipe_flush 1 for cycles 1-3.
REQ-042 mret with mepc_rdata=0x104 -> pc_next=0x104 at cycle 1; no CSR writes.
REQ-043 trap_taken, mret and branch_taken in the same cycle -> trap sequence only; branch_taken pulsed during W_MCAUSE -> ignored, so exactly one pc_load per sequence.
REQ-044 rst_n=0 during W_MCAUSE -> no 343 write; all outputs 0 next cycle; after release, a branch is accepted normally.
REQ-045 FLUSH_CYCLES=1 and 15, each with back-to-back branches -> flush lengths 2 and 16 cycles; second event accepted on the first IDLE cycle.
